// File: rtl/riscv_chk_pkg.sv
// Shared types for the RISC-V commit checker.
//   exp_kind_e  : kind of architectural event an expectation describes
//   chk_state_e : checker FSM state (also exported on the debug port)
//   exp_entry_t : field order of one queued expectation (kind, idx, value)
//                 shown at the default 32-bit width; the top packs the same
//                 order at its own XLEN when storing into the FIFO.
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    SKIP = 2'd0,
    PC   = 2'd1,
    REG  = 2'd2,
    MEM  = 2'd3
  } exp_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    HALT = 2'd3
  } chk_state_e;

  localparam int ENTRY_XLEN = 32;

  typedef struct packed {
    exp_kind_e             kind;
    logic [ENTRY_XLEN-1:0] idx;
    logic [ENTRY_XLEN-1:0] value;
  } exp_entry_t;

  // Bits needed to store one expectation at a given data width.
  function automatic int entry_width(input int xlen);
    return 2 + 2 * xlen;
  endfunction

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO holding queued expectations.
//   clk, reset : clock, synchronous active-high reset (pointers only)
//   push, din  : write din at the tail this cycle
//   pop        : advance the head this cycle
//   head       : combinational view of the oldest entry
//   full/empty : occupancy flags
// The caller only asserts push when there is room (or a pop frees the slot
// in the same cycle) and only asserts pop when not empty.
// Occupancy uses one extra pointer bit so full and empty are distinguishable
// when the index bits coincide; DEPTH must be a power of two.
module chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only visible after it was written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/riscv_commit_checker.sv
// Self-checker for a single-cycle RISC-V core.
// Expectations (SKIP / PC / REG / MEM) are queued through exp_*; every
// retiring instruction in RUN pops one and compares it with the commit
// signals. Results are registered one edge after the commit cycle.
//   clk, reset, start            : clock, sync active-high reset, IDLE->RUN pulse
//   exp_valid/ready/kind/idx/value : expectation push interface
//   commit_valid, commit_pc,
//   rd_we/addr/data, mem_we/addr/wdata : core commit signals
//   pass_cnt, err_cnt, test_cnt  : saturating counters
//   mismatch                     : one-cycle pulse per failed check
//   fail, underrun               : sticky flags
//   first_err_num/act            : test number and actual value of first failure
//   done                         : state is DONE or HALT
//   state                        : FSM state (debug)
//
// Handshake: a push is taken when exp_valid is high and the queue has room,
// in any state but HALT. exp_ready reflects only the registered full flag;
// a push presented while full is still taken if a check pops the head in the
// same cycle (occupancy unchanged), otherwise it is silently dropped.
module riscv_commit_checker
  import riscv_chk_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int DEPTH       = 32,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [1:0]        exp_kind,
  input  logic [XLEN-1:0]   exp_idx,
  input  logic [XLEN-1:0]   exp_value,
  input  logic              commit_valid,
  input  logic [XLEN-1:0]   commit_pc,
  input  logic              rd_we,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [XLEN-1:0]   rd_data,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  test_cnt,
  output logic              mismatch,
  output logic              fail,
  output logic              underrun,
  output logic [CNT_W-1:0]  first_err_num,
  output logic [XLEN-1:0]   first_err_act,
  output logic              done,
  output chk_state_e        state
);

  localparam int EW = entry_width(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  chk_state_e      state_q, state_d;
  logic            full, empty;
  logic [EW-1:0]   head_raw;
  exp_kind_e       head_kind;
  logic [XLEN-1:0] head_idx, head_value;
  logic            do_check, push_ok, check_pass;
  logic [XLEN-1:0] check_act;

  assign head_kind  = exp_kind_e'(head_raw[EW-1 -: 2]);
  assign head_idx   = head_raw[2*XLEN-1 -: XLEN];
  assign head_value = head_raw[XLEN-1:0];

  assign do_check  = (state_q == RUN) && commit_valid && !empty;
  assign push_ok   = exp_valid && (state_q != HALT) && (!full || do_check);
  assign exp_ready = !full;
  assign done      = (state_q == DONE) || (state_q == HALT);
  assign state     = state_q;

  chk_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .din   ({exp_kind, exp_idx, exp_value}),
    .pop   (do_check),
    .head  (head_raw),
    .full  (full),
    .empty (empty)
  );

  // Compare the head entry against this cycle's commit.
  // The actual value is captured even when the write-enable is low.
  always_comb begin
    check_pass = 1'b0;
    check_act  = '0;
    case (head_kind)
      SKIP: check_pass = 1'b1;
      PC: begin
        check_pass = (commit_pc == head_value);
        check_act  = commit_pc;
      end
      REG: begin
        // x0 is hardwired to zero, so an expected write to it never matches.
        check_pass = rd_we && (rd_addr != '0) && (rd_addr == head_idx[REG_AW-1:0])
                     && (rd_data == head_value);
        check_act  = rd_data;
      end
      MEM: begin
        check_pass = mem_we && (mem_addr == head_idx) && (mem_wdata == head_value);
        check_act  = mem_wdata;
      end
      default: check_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if ((STOP_ON_ERR != 0) && do_check && !check_pass) state_d = HALT;
        else if (empty && !push_ok)                        state_d = DONE;
      end
      DONE: if (push_ok) state_d = RUN;
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pass_cnt      <= '0;
      err_cnt       <= '0;
      test_cnt      <= '0;
      mismatch      <= 1'b0;
      fail          <= 1'b0;
      underrun      <= 1'b0;
      first_err_num <= '0;
      first_err_act <= '0;
    end else begin
      state_q  <= state_d;
      mismatch <= 1'b0;
      if (do_check) begin
        test_cnt <= sat_inc(test_cnt);
        if (check_pass) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          err_cnt  <= sat_inc(err_cnt);
          mismatch <= 1'b1;
          fail     <= 1'b1;
          if (!fail) begin
            first_err_num <= test_cnt;
            first_err_act <= check_act;
          end
        end
      end
      if ((state_q == RUN) && commit_valid && empty) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Directed bench for riscv_commit_checker. Two instances share all inputs:
//   dut_a : DEPTH=4, CNT_W=16, STOP_ON_ERR=0
//   dut_b : DEPTH=4, CNT_W=2,  STOP_ON_ERR=1 (halt and saturation cases)
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_riscv_commit_checker;
  import riscv_chk_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        start, exp_valid, commit_valid, rd_we, mem_we;
  logic [1:0]  exp_kind;
  logic [31:0] exp_idx, exp_value, commit_pc, rd_data, mem_addr, mem_wdata;
  logic [4:0]  rd_addr;

  // ---------------- dut_a outputs ----------------
  logic        exp_ready_a, mismatch_a, fail_a, underrun_a, done_a;
  logic [15:0] pass_cnt_a, err_cnt_a, test_cnt_a, first_err_num_a;
  logic [31:0] first_err_act_a;
  chk_state_e  state_a;

  // ---------------- dut_b outputs ----------------
  logic        exp_ready_b, mismatch_b, fail_b, underrun_b, done_b;
  logic [1:0]  pass_cnt_b, err_cnt_b, test_cnt_b, first_err_num_b;
  logic [31:0] first_err_act_b;
  chk_state_e  state_b;

  riscv_commit_checker #(
    .XLEN(32), .REG_AW(5), .DEPTH(4), .CNT_W(16), .STOP_ON_ERR(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready_a), .exp_kind(exp_kind),
    .exp_idx(exp_idx), .exp_value(exp_value),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pass_cnt(pass_cnt_a), .err_cnt(err_cnt_a), .test_cnt(test_cnt_a),
    .mismatch(mismatch_a), .fail(fail_a), .underrun(underrun_a),
    .first_err_num(first_err_num_a), .first_err_act(first_err_act_a),
    .done(done_a), .state(state_a)
  );

  riscv_commit_checker #(
    .XLEN(32), .REG_AW(5), .DEPTH(4), .CNT_W(2), .STOP_ON_ERR(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start),
    .exp_valid(exp_valid), .exp_ready(exp_ready_b), .exp_kind(exp_kind),
    .exp_idx(exp_idx), .exp_value(exp_value),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pass_cnt(pass_cnt_b), .err_cnt(err_cnt_b), .test_cnt(test_cnt_b),
    .mismatch(mismatch_b), .fail(fail_b), .underrun(underrun_b),
    .first_err_num(first_err_num_b), .first_err_act(first_err_act_b),
    .done(done_b), .state(state_b)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; exp_valid = 0; exp_kind = 0; exp_idx = 0; exp_value = 0;
    commit_valid = 0; commit_pc = 0; rd_we = 0; rd_addr = 0; rd_data = 0;
    mem_we = 0; mem_addr = 0; mem_wdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic push(input logic [1:0] kind, input logic [31:0] idx, input logic [31:0] val);
    exp_valid = 1; exp_kind = kind; exp_idx = idx; exp_value = val;
    tick();
    exp_valid = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // One retiring instruction; any exp_* push set up by the caller rides along.
  task automatic commit(input logic [31:0] pc, input logic we, input logic [4:0] ra,
                        input logic [31:0] rdat, input logic mwe, input logic [31:0] ma,
                        input logic [31:0] md);
    commit_valid = 1; commit_pc = pc; rd_we = we; rd_addr = ra; rd_data = rdat;
    mem_we = mwe; mem_addr = ma; mem_wdata = md;
    tick();
    commit_valid = 0; rd_we = 0; mem_we = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1;
    clear_inputs();
    tick();
    do_reset();

    // Reset state
    check_eq("rst_test_cnt", 64'(test_cnt_a), 0);
    check_eq("rst_pass_cnt", 64'(pass_cnt_a), 0);
    check_eq("rst_fail", 64'(fail_a), 0);
    check_eq("rst_done", 64'(done_a), 0);
    check_eq("rst_ready", 64'(exp_ready_a), 1);
    check_eq("rst_state", 64'(state_a), 64'(IDLE));

    // Directed program run
    push(2'd2, 32'd2, 32'd5);
    push(2'd2, 32'd3, 32'd12);
    push(2'd1, 32'd0, 32'h1C);
    push(2'd3, 32'd96, 32'd7);
    check_eq("prog_full_ready", 64'(exp_ready_a), 0);
    pulse_start();
    check_eq("prog_state_run", 64'(state_a), 64'(RUN));
    commit(32'h04, 1, 5'd2, 32'd5, 0, 0, 0);
    check_eq("prog_pass1", 64'(pass_cnt_a), 1);
    commit(32'h08, 1, 5'd3, 32'd12, 0, 0, 0);
    commit(32'h1C, 0, 5'd0, 32'd0, 0, 0, 0);
    commit(32'h20, 0, 5'd0, 32'd0, 1, 32'd96, 32'd7);
    check_eq("prog_test_cnt", 64'(test_cnt_a), 4);
    check_eq("prog_pass_cnt", 64'(pass_cnt_a), 4);
    check_eq("prog_err_cnt", 64'(err_cnt_a), 0);
    check_eq("prog_fail", 64'(fail_a), 0);
    check_eq("prog_done_early", 64'(done_a), 0);
    tick();
    check_eq("prog_done", 64'(done_a), 1);

    // Mismatch capture
    do_reset();
    push(2'd2, 32'd4, 32'd0);
    push(2'd2, 32'd9, 32'd18);
    pulse_start();
    commit(32'h04, 1, 5'd4, 32'd3, 0, 0, 0);
    check_eq("mm_pulse", 64'(mismatch_a), 1);
    check_eq("mm_err_cnt", 64'(err_cnt_a), 1);
    check_eq("mm_first_num", 64'(first_err_num_a), 0);
    check_eq("mm_first_act", 64'(first_err_act_a), 3);
    check_eq("mm_fail", 64'(fail_a), 1);
    commit(32'h08, 1, 5'd9, 32'd18, 0, 0, 0);
    check_eq("mm_pulse_end", 64'(mismatch_a), 0);
    check_eq("mm_pass_cnt", 64'(pass_cnt_a), 1);
    check_eq("mm_test_cnt", 64'(test_cnt_a), 2);
    check_eq("mm_first_act_hold", 64'(first_err_act_a), 3);

    // STOP_ON_ERR on dut_b
    do_reset();
    push(2'd1, 32'd0, 32'h28);
    push(2'd1, 32'd0, 32'h48);
    pulse_start();
    commit(32'h2C, 0, 0, 0, 0, 0, 0);
    check_eq("halt_state", 64'(state_b), 64'(HALT));
    check_eq("halt_done", 64'(done_b), 1);
    check_eq("halt_test_cnt", 64'(test_cnt_b), 1);
    commit(32'h48, 0, 0, 0, 0, 0, 0);
    check_eq("halt_no_second", 64'(test_cnt_b), 1);
    // Three pushes would fill the queue (1 left + 3) if HALT accepted them.
    push(2'd0, 0, 0);
    push(2'd0, 0, 0);
    push(2'd0, 0, 0);
    check_eq("halt_push_ignored", 64'(exp_ready_b), 1);
    check_eq("halt_sticky", 64'(state_b), 64'(HALT));
    do_reset();
    check_eq("halt_reset_state", 64'(state_b), 64'(IDLE));
    check_eq("halt_reset_done", 64'(done_b), 0);

    // Full / wrap / saturation
    do_reset();
    for (int i = 0; i < 4; i++) push(2'd0, 32'(i), 32'($urandom_range(0, 255)));
    check_eq("full_ready", 64'(exp_ready_a), 0);
    push(2'd1, 0, 32'hDEAD);  // dropped: queue full and no pop in IDLE
    check_eq("full_drop_ready", 64'(exp_ready_a), 0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      exp_valid = 1; exp_kind = 2'd0; exp_idx = 0; exp_value = 32'(i);
      commit(32'h100, 0, 0, 0, 0, 0, 0);
      exp_valid = 0;
      check_eq("full_pushpop_ready", 64'(exp_ready_a), 0);
    end
    for (int i = 0; i < 4; i++) commit(32'h200, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_test_cnt", 64'(test_cnt_a), 8);
    check_eq("wrap_pass_cnt", 64'(pass_cnt_a), 8);
    check_eq("wrap_err_cnt", 64'(err_cnt_a), 0);
    check_eq("sat_pass_cnt", 64'(pass_cnt_b), 3);
    check_eq("sat_test_cnt", 64'(test_cnt_b), 3);
    check_eq("sat_err_cnt", 64'(err_cnt_b), 0);
    tick();
    check_eq("wrap_done", 64'(done_a), 1);

    // Underrun / skip / x0
    do_reset();
    pulse_start();
    commit(0, 0, 0, 0, 0, 0, 0);
    check_eq("ur_flag", 64'(underrun_a), 1);
    check_eq("ur_test_cnt", 64'(test_cnt_a), 0);
    check_eq("ur_state_done", 64'(state_a), 64'(DONE));
    push(2'd0, 0, 0);
    check_eq("ur_done_to_run", 64'(state_a), 64'(RUN));
    commit(0, 0, 0, 0, 0, 0, 0);
    check_eq("skip_pass", 64'(pass_cnt_a), 1);
    push(2'd2, 0, 0);
    commit(0, 1, 5'd0, 32'd0, 0, 0, 0);
    check_eq("x0_err_cnt", 64'(err_cnt_a), 1);
    check_eq("x0_mismatch", 64'(mismatch_a), 1);
    check_eq("x0_first_num", 64'(first_err_num_a), 1);
    check_eq("ur_sticky", 64'(underrun_a), 1);

    // Reset mid-run
    do_reset();
    push(2'd1, 0, 32'h10);
    push(2'd0, 0, 0);
    push(2'd0, 0, 0);
    pulse_start();
    commit(32'h14, 0, 0, 0, 0, 0, 0);
    commit(32'h18, 0, 0, 0, 0, 0, 0);
    check_eq("mid_test_cnt", 64'(test_cnt_a), 2);
    check_eq("mid_first_act", 64'(first_err_act_a), 32'h14);
    reset = 1;
    tick();
    reset = 0;
    check_eq("mid_rst_test_cnt", 64'(test_cnt_a), 0);
    check_eq("mid_rst_pass_cnt", 64'(pass_cnt_a), 0);
    check_eq("mid_rst_err_cnt", 64'(err_cnt_a), 0);
    check_eq("mid_rst_fail", 64'(fail_a), 0);
    check_eq("mid_rst_first_num", 64'(first_err_num_a), 0);
    check_eq("mid_rst_first_act", 64'(first_err_act_a), 0);
    check_eq("mid_rst_state", 64'(state_a), 64'(IDLE));
    check_eq("mid_rst_ready", 64'(exp_ready_a), 1);
    // With an empty queue RUN falls through to DONE on the next edge.
    pulse_start();
    tick();
    check_eq("mid_rst_empty", 64'(done_a), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_commit_checker.md
Name: riscv_commit_checker

Overview:
- Synthesizable, parametrised self-checker that follows the single-cycle RISC-V core.
- Holds a queue of expected architectural events: PC value, register-file write, or data-memory write.
- Pops one expectation per retired instruction and compares it against the core's commit signals.
- Keeps pass/error/total counters and a first-failure record, so the same check flow runs in simulation, emulation, or on FPGA without hierarchical probes.

Parameters:
- XLEN, 32, data/PC/memory-address width.
- REG_AW, 5, register-index width.
- DEPTH, 32, expectation-queue entries (power of two, >=2).
- CNT_W, 16, width of the pass/error/test counters (saturating).
- STOP_ON_ERR, 0, 1 = freeze checking at the first mismatch.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; IDLE->RUN.
- exp_valid  in  1  expectation push request.
- exp_ready  out  1  queue not full.
- exp_kind  in  2  0 SKIP, 1 PC, 2 REG, 3 MEM.
- exp_idx  in  XLEN  register index (low REG_AW bits) or memory address.
- exp_value  in  XLEN  expected value.
- commit_valid  in  1  an instruction retires this cycle.
- commit_pc  in  XLEN  PC after the retiring instruction.
- rd_we  in  1  register write of the retiring instruction.
- rd_addr  in  REG_AW  destination register.
- rd_data  in  XLEN  register write data.
- mem_we  in  1  store of the retiring instruction.
- mem_addr  in  XLEN  store address.
- mem_wdata  in  XLEN  store data.
- pass_cnt, err_cnt, test_cnt  out  CNT_W each  saturating counters.
- mismatch  out  1  one-cycle pulse per failed check.
- fail  out  1  sticky; any mismatch seen.
- underrun  out  1  sticky; commit arrived in RUN with an empty queue.
- first_err_num  out  CNT_W  value of test_cnt at the first failure.
- first_err_act  out  XLEN  actual value compared at the first failure.
- done  out  1  state is DONE or HALT.

Behaviour:
- Reset (synchronous, active-high) clears all of the following to 0, whatever the current state, including mid-RUN:
  - all counters and flags, and first_err_*;
  - the queue pointers; the queue is empty after reset;
  - state = IDLE.
- exp_ready = !full. A push is accepted when exp_valid && exp_ready, in any state except HALT. A push while full is dropped and does not stall.
- FSM:
  - IDLE: start -> RUN. Commits are ignored.
  - RUN: each commit_valid pops the head entry and performs a check. If the queue is empty at the commit, there is no pop, no check, and underrun is set.
  - RUN -> DONE when the queue is empty and no push is accepted in that cycle, one cycle after the last pop.
  - RUN -> HALT on a mismatch when STOP_ON_ERR = 1.
  - DONE: a push returns the FSM to RUN.
  - HALT: terminal until reset.
- Check rules. The compare is combinational on the head entry; the result is registered, so counters, mismatch and first_err_* update at the edge ending the commit cycle (latency 1).
  - SKIP: counts as a pass, and test_cnt increments.
  - PC: pass iff commit_pc == exp_value.
  - REG: pass iff rd_we && rd_addr == exp_idx[REG_AW-1:0] && rd_data == exp_value. A write to x0 never passes.
  - MEM: pass iff mem_we && mem_addr == exp_idx && mem_wdata == exp_value.
- Actual value captured into first_err_act: commit_pc for PC, rd_data for REG, mem_wdata for MEM, even when a write-enable is low.
- Counter update per check: test_cnt+1, plus pass_cnt+1 or err_cnt+1. Each counter saturates at all-ones, and saturation is independent per counter.
- first_err_* is loaded only while fail = 0; fail sets on the same edge.
- A simultaneous push and pop on a full queue is allowed. exp_ready is computed from the current full flag, and occupancy is unchanged.
- The queue wraps modulo DEPTH; occupancy is tracked with an extra pointer bit.
- Commits during DONE are ignored, with no underrun.

Decomposition:
- Package riscv_chk_pkg holds:
  - exp_kind_e, 2-bit enum: SKIP, PC, REG, MEM;
  - exp_entry_t, a struct of kind, idx, value;
  - chk_state_e: IDLE, RUN, DONE, HALT.
- Sub-module chk_fifo: a synchronous FIFO with parameters WIDTH and DEPTH, plus push, pop, full, empty and head data, reset on the synchronous active-high reset.
- Compare logic and the FSM stay in the top module.

Test Plan:
- Directed program run:
  - Push REG(2,5), REG(3,12), PC(0x1C), MEM(96,7); start.
  - Drive matching commits: x2<-5, x3<-12, pc=0x1C, store 96<-7.
  - Expect test_cnt=4, pass_cnt=4, err_cnt=0, fail=0; done one cycle after the last check.
- Mismatch capture:
  - Push REG(4,0), REG(9,18); commit x4<-3, then x9<-18.
  - Expect a mismatch pulse on the first check; err_cnt=1, pass_cnt=1.
  - Expect first_err_num=0, first_err_act=3, fail=1.
- STOP_ON_ERR=1:
  - Push PC(0x28), PC(0x48); commit pc=0x2C.
  - Expect HALT with done=1 and the second entry never checked (test_cnt=1).
  - A push in HALT is ignored; the state leaves HALT only after reset.
- Full/wrap, DEPTH=4:
  - Push 4 entries; exp_ready=0 and a 5th push is dropped.
  - Push and pop in the same cycle while full; occupancy stays 4.
  - Run 8 SKIP checks across a pointer wrap; test_cnt=8.
- Underrun/skip:
  - Start with an empty queue and commit once: underrun=1, test_cnt=0.
  - A SKIP entry with rd_we=0 passes.
  - REG(0,0) with a write to x0 fails.
- Reset mid-run and saturation:
  - Assert reset after 2 checks: all outputs return to 0, the state returns to IDLE, and the queue is empty.
  - With CNT_W=2, 5 passing checks leave pass_cnt=3 and test_cnt=3.
